m_switch_allocator: RTL and testbench

M_SWITCH_ALLOCATOR -- requirements
Module: m_Switch_Allocator

---
 rtl/m_switch_allocator_pkg.sv | 33 +++
 rtl/m_switch_allocator_if.sv | 30 +++
 rtl/m_switch_allocator_rr_arbiter.sv | 39 +++
 rtl/m_switch_allocator.sv | 104 ++++++++++
 tb/tb_m_switch_allocator.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/m_switch_allocator_pkg.sv
// Shared constants, state encodings and index helpers for the 5-port switch allocator.
package m_switch_allocator_pkg;
  localparam int N_PORTS = 5;
  localparam int SEL_W   = N_PORTS;
  localparam int IDX_W   = 3;

  typedef logic [SEL_W-1:0] port_vec_t;
  typedef logic [IDX_W-1:0] port_idx_t;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // (a + b) mod N_PORTS for a, b already in range
  function automatic port_idx_t wrap_add(input port_idx_t a, input port_idx_t b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_PORTS[IDX_W:0]) s = s - N_PORTS[IDX_W:0];
    return s[IDX_W-1:0];
  endfunction

  function automatic port_vec_t lowest_onehot(input port_vec_t v);
    return v & (~v + port_vec_t'(1));
  endfunction

  function automatic port_idx_t onehot_to_idx(input port_vec_t v);
    port_idx_t idx;
    idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (v[i]) idx = idx | i[IDX_W-1:0];
    end
    return idx;
  endfunction
endpackage

// File: rtl/m_switch_allocator_if.sv
// Router-side bundle: per-input flit status and routing requests in, per-output selects and grants out.
interface m_switch_allocator_if;
  import m_switch_allocator_pkg::*;

  // Handshake: input i's flit moves when grant[i] is high in a cycle; grant[i] is only
  // raised when flit_valid[i] and out_ready of the owned output are both high, and the
  // input pops its buffer on that same edge.
  port_vec_t                    flit_valid;
  port_vec_t                    flit_head;
  port_vec_t                    flit_tail;
  logic [N_PORTS*N_PORTS-1:0]   req_dst;
  port_vec_t                    out_ready;
  port_vec_t                    sel_0;
  port_vec_t                    sel_1;
  port_vec_t                    sel_2;
  port_vec_t                    sel_3;
  port_vec_t                    sel_4;
  port_vec_t                    grant;
  port_vec_t                    dbg_state;

  modport master (
    output flit_valid, flit_head, flit_tail, req_dst, out_ready,
    input  sel_0, sel_1, sel_2, sel_3, sel_4, grant, dbg_state
  );

  modport slave (
    input  flit_valid, flit_head, flit_tail, req_dst, out_ready,
    output sel_0, sel_1, sel_2, sel_3, sel_4, grant, dbg_state
  );
endinterface

// File: rtl/m_switch_allocator_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a registered pointer, pointer loaded on release.
module m_switch_allocator_rr_arbiter
  import m_switch_allocator_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  port_vec_t req,
  input  logic      ptr_upd,
  input  port_idx_t ptr_nxt,
  output port_vec_t gnt
);

  port_idx_t ptr_q;
  port_idx_t idx;
  logic      found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (ptr_upd) begin
      ptr_q <= ptr_nxt;
    end
  end

  // Search ptr_q, ptr_q+1, ... so the pointer position itself has top priority
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < N_PORTS; off++) begin
      idx = wrap_add(ptr_q, off[IDX_W-1:0]);
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_switch_allocator.sv
// Switch allocator: per-output IDLE/LOCKED FSM holding a wormhole lock from head to tail flit.
module m_switch_allocator
  import m_switch_allocator_pkg::*;
#(
  parameter int P_PORTS = N_PORTS
)(
  input logic                  clk,
  input logic                  rst,
  m_switch_allocator_if.slave  bus
);

  logic [N_PORTS-1:0][0:0]  state_q;
  port_vec_t [N_PORTS-1:0]  sel_q;
  port_vec_t [N_PORTS-1:0]  arb_req;
  port_vec_t [N_PORTS-1:0]  arb_gnt;
  port_idx_t [N_PORTS-1:0]  ptr_nxt;
  port_vec_t                locked;
  port_vec_t                xfer;
  port_vec_t                rel;
  port_vec_t                busy;
  port_vec_t                grant_c;
  port_vec_t                dst_low;

  // Per-output transfer status; busy marks inputs that already own an output
  always_comb begin
    locked  = '0;
    xfer    = '0;
    rel     = '0;
    busy    = '0;
    grant_c = '0;
    ptr_nxt = '0;
    for (int k = 0; k < P_PORTS; k++) begin
      locked[k]  = (state_q[k] == ST_LOCKED);
      xfer[k]    = locked[k] & (|(sel_q[k] & bus.flit_valid)) & bus.out_ready[k];
      rel[k]     = xfer[k] & (|(sel_q[k] & bus.flit_tail));
      ptr_nxt[k] = wrap_add(onehot_to_idx(sel_q[k]), port_idx_t'(1));
      if (locked[k]) busy    = busy | sel_q[k];
      if (xfer[k])   grant_c = grant_c | sel_q[k];
    end
  end

  // Only valid head flits from free inputs arbitrate, and only at idle outputs
  always_comb begin
    arb_req = '0;
    dst_low = '0;
    for (int i = 0; i < P_PORTS; i++) begin
      dst_low = lowest_onehot(bus.req_dst[i*N_PORTS +: N_PORTS]);
      for (int k = 0; k < P_PORTS; k++) begin
        arb_req[k][i] = bus.flit_valid[i] & bus.flit_head[i] & dst_low[k] &
                        ~busy[i] & ~locked[k];
      end
    end
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_arb
    m_switch_allocator_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req[k]),
      .ptr_upd (rel[k]),
      .ptr_nxt (ptr_nxt[k]),
      .gnt     (arb_gnt[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < P_PORTS; k++) begin
        state_q[k] <= ST_IDLE;
        sel_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < P_PORTS; k++) begin
        case (state_q[k])
          ST_IDLE: begin
            if (|arb_gnt[k]) begin
              state_q[k] <= ST_LOCKED;
              sel_q[k]   <= arb_gnt[k];
            end
          end
          ST_LOCKED: begin
            if (rel[k]) begin
              state_q[k] <= ST_IDLE;
              sel_q[k]   <= '0;
            end
          end
          default: begin
            state_q[k] <= ST_IDLE;
            sel_q[k]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.sel_0     = sel_q[0];
  assign bus.sel_1     = sel_q[1];
  assign bus.sel_2     = sel_q[2];
  assign bus.sel_3     = sel_q[3];
  assign bus.sel_4     = sel_q[4];
  assign bus.grant     = grant_c;
  assign bus.dbg_state = locked;

endmodule

// File: tb/tb_m_switch_allocator.sv
// Bench for m_switch_allocator: directed scenarios then random traffic against an integer-level model.
module tb_m_switch_allocator;
  import m_switch_allocator_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m_switch_allocator_if bus ();

  m_switch_allocator #(.P_PORTS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  // reference model: per-output lock flag, owner input number and pointer
  bit m_locked[5];
  int m_owner[5];
  int m_ptr[5];

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] get_sel(input int k);
    case (k)
      0:       return bus.sel_0;
      1:       return bus.sel_1;
      2:       return bus.sel_2;
      3:       return bus.sel_3;
      default: return bus.sel_4;
    endcase
  endfunction

  function automatic int low_dst(input int i);
    logic [4:0] d;
    d = bus.req_dst[i*5 +: 5];
    for (int j = 0; j < 5; j++) if (d[j]) return j;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_locked[k] = 1'b0;
      m_owner[k]  = 0;
      m_ptr[k]    = 0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4:0] eg;
    logic [4:0] es;
    eg = '0;
    for (int k = 0; k < 5; k++)
      if (m_locked[k] && bus.flit_valid[m_owner[k]] && bus.out_ready[k]) eg[m_owner[k]] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      es = m_locked[k] ? (5'b00001 << m_owner[k]) : 5'b00000;
      chk($sformatf("%s.sel_%0d", tag, k), get_sel(k), es);
    end
    chk({tag, ".grant"}, bus.grant, eg);
  endtask

  task automatic model_step();
    bit own_any[5];
    int o;
    int i;
    if (!rst) begin
      for (int k = 0; k < 5; k++) own_any[k] = 1'b0;
      for (int k = 0; k < 5; k++) if (m_locked[k]) own_any[m_owner[k]] = 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (m_locked[k]) begin
          o = m_owner[k];
          if (bus.flit_valid[o] && bus.out_ready[k] && bus.flit_tail[o]) begin
            m_locked[k] = 1'b0;
            m_ptr[k]    = (o + 1) % 5;
          end
        end else begin
          for (int off = 0; off < 5; off++) begin
            i = (m_ptr[k] + off) % 5;
            if (bus.flit_valid[i] && bus.flit_head[i] && low_dst(i) == k && !own_any[i]) begin
              m_locked[k] = 1'b1;
              m_owner[k]  = i;
              break;
            end
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic drive(input logic [4:0] v, input logic [4:0] h, input logic [4:0] t,
                       input logic [24:0] d, input logic [4:0] r);
    bus.flit_valid = v;
    bus.flit_head  = h;
    bus.flit_tail  = t;
    bus.req_dst    = d;
    bus.out_ready  = r;
  endtask

  task automatic tick(input string tag);
    check_outputs(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    @(negedge clk);
    tick(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  v, h, t, r, e;
    logic [24:0] d;
    int          pick;

    // reset state
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    model_reset();
    @(negedge clk);
    chk("reset.grant", bus.grant, 5'b00000);
    tick("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single-flit packet, input 0 -> output 2
    drive(5'b00001, 5'b00001, 5'b00001, {20'b0, 5'b00100}, 5'b11111);
    cyc("single.t0");
    @(negedge clk);
    chk("single.sel2_t1", bus.sel_2, 5'b00001);
    chk("single.grant_t1", bus.grant, 5'b00001);
    tick("single.t1");
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    @(negedge clk);
    chk("single.sel2_t2", bus.sel_2, 5'b00000);
    tick("single.t2");

    // contention: inputs 1,3,4 to output 0, expected lock order 1,3,4
    v = 5'b11010;
    d = {5'b00001, 5'b00001, 5'b00000, 5'b00001, 5'b00000};
    drive(v, v, v, d, 5'b11111);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10000);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("contend.bubble", bus.sel_0, 5'b00000);
      tick("contend.idle");
      @(negedge clk);
      e = exp_q.pop_front();
      chk("contend.order", bus.sel_0, e);
      chk("contend.grant", bus.grant, e);
      tick("contend.lock");
      v = v & ~e;
      drive(v, v, v, d, 5'b11111);
    end
    cyc("contend.done");
    // pointer wrapped to 0: input 0 beats input 4
    v = 5'b10001;
    d = {5'b00001, 15'b0, 5'b00001};
    drive(v, v, v, d, 5'b11111);
    cyc("contend.ptr_t0");
    @(negedge clk);
    chk("contend.ptr_wrap", bus.sel_0, 5'b00001);
    tick("contend.ptr_t1");
    drive(5'b10000, 5'b10000, 5'b10000, d, 5'b11111);
    cyc("contend.ptr_t2");
    cyc("contend.ptr_t3");
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    cyc("contend.ptr_t4");

    // parallel: input i -> output 4-i
    d = {5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
    drive(5'b11111, 5'b11111, 5'b11111, d, 5'b11111);
    cyc("parallel.t0");
    @(negedge clk);
    chk("parallel.grant", bus.grant, 5'b11111);
    chk("parallel.sel0", bus.sel_0, 5'b10000);
    chk("parallel.sel4", bus.sel_4, 5'b00001);
    tick("parallel.t1");
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    cyc("parallel.t2");

    // backpressure: 3-flit packet input 2 -> output 4
    d = {10'b0, 5'b10000, 10'b0};
    drive(5'b00100, 5'b00100, 5'b00000, d, 5'b01111);
    cyc("bp.lock");
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("bp.hold_sel4", bus.sel_4, 5'b00100);
      chk("bp.hold_grant", bus.grant, 5'b00000);
      tick("bp.stall");
    end
    drive(5'b00100, 5'b00100, 5'b00000, d, 5'b11111);
    @(negedge clk);
    chk("bp.head_grant", bus.grant, 5'b00100);
    tick("bp.head");
    drive(5'b00100, 5'b00000, 5'b00000, d, 5'b11111);
    @(negedge clk);
    chk("bp.body_grant", bus.grant, 5'b00100);
    tick("bp.body");
    drive(5'b00000, 5'b00000, 5'b00000, d, 5'b11111);
    @(negedge clk);
    chk("bp.gap_sel4", bus.sel_4, 5'b00100);
    tick("bp.gap");
    drive(5'b00100, 5'b00000, 5'b00100, d, 5'b11111);
    @(negedge clk);
    chk("bp.tail_grant", bus.grant, 5'b00100);
    tick("bp.tail");
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    @(negedge clk);
    chk("bp.released", bus.sel_4, 5'b00000);
    tick("bp.idle");

    // non-one-hot request: only lowest bit honoured
    drive(5'b00010, 5'b00010, 5'b00010, {15'b0, 5'b10010, 5'b0}, 5'b11111);
    cyc("illegal.t0");
    @(negedge clk);
    chk("illegal.sel1", bus.sel_1, 5'b00010);
    chk("illegal.sel4", bus.sel_4, 5'b00000);
    tick("illegal.t1");
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    cyc("illegal.t2");

    // reset mid-packet: output 2 locked to input 1
    d = {15'b0, 5'b00100, 5'b0};
    drive(5'b00010, 5'b00010, 5'b00000, d, 5'b11111);
    cyc("rstmid.lock");
    @(negedge clk);
    chk("rstmid.sel2", bus.sel_2, 5'b00010);
    tick("rstmid.head");
    drive(5'b00010, 5'b00000, 5'b00000, d, 5'b11011);
    cyc("rstmid.stall");
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rstmid.sel2_rst", bus.sel_2, 5'b00000);
    chk("rstmid.grant_rst", bus.grant, 5'b00000);
    tick("rstmid.in_rst");
    rst = 1'b0;
    drive(5'b00010, 5'b00000, 5'b00000, d, 5'b11111);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rstmid.no_grant", bus.grant, 5'b00000);
      tick("rstmid.after");
    end
    drive(5'b0, 5'b0, 5'b0, 25'b0, 5'b11111);
    cyc("rstmid.end");

    // random traffic
    for (int c = 0; c < 600; c++) begin
      v = 5'($urandom) | 5'($urandom);
      h = 5'($urandom);
      t = 5'($urandom);
      r = 5'($urandom) | 5'($urandom);
      d = '0;
      for (int i = 0; i < 5; i++) begin
        pick = $urandom_range(0, 9);
        if (pick < 7)      d[i*5 +: 5] = 5'b00001 << $urandom_range(0, 4);
        else if (pick < 9) d[i*5 +: 5] = 5'($urandom);
      end
      rst = ($urandom_range(0, 199) == 0);
      if (rst) model_reset();
      drive(v, h, t, d, r);
      cyc($sformatf("rand%0d", c));
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
